// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: linear framebuffer prefetch feeding the VGA timing stage.
// Issues one credit-limited read per cycle, tags returns with a fixed-latency
// valid pipe and buffers pixels in a show-ahead FIFO.
// Optional build macro VGA_PIXEL_FETCH_TESTPAT_EN replaces memory data with
// 8 vertical colour bars; timing, credit and latency are unchanged.
module vga_pixel_fetch #(
  parameter int H_VISIBLE  = 800,
  parameter int V_VISIBLE  = 600,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 19
) (
  input  logic              VGA_CLK,
  input  logic              VGA_RST,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [11:0]       pix_data,
  output logic              pix_valid,
  output logic              underrun,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [11:0]       fb_rd_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     addr;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [11:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           inflight, credit_used;
  logic                  issue, push, pop;
  logic [11:0]           wr_data;

  // Credit: FIFO occupancy plus every read not yet landed must stay below depth
  always_comb begin
    inflight = (CW+1)'(fb_rd_en);
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + (CW+1)'(vld_pipe[i]);
    credit_used = {1'b0, count} + inflight;
    issue = (state == FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
  end

  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? mem[rd_ptr] : 12'h000;
  // frame_start wins: stale returns and concurrent requests are dropped
  assign push = vld_pipe[RD_LATENCY-1] & ~frame_start;
  assign pop  = pix_req & pix_valid & ~frame_start;

  // Fetch FSM with registered read strobe/address; stops after last address
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      state      <= IDLE;
      addr       <= '0;
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else if (frame_start) begin
      state    <= FETCH;
      addr     <= '0;
      fb_rd_en <= 1'b0;
    end else begin
      fb_rd_en <= issue;
      if (issue) begin
        fb_rd_addr <= addr;
        addr       <= addr + 1'b1;
        if (addr == LAST_ADDR) state <= DONE;
      end
    end
  end

  // Return tags: a read issued this cycle lands RD_LATENCY cycles later
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST || frame_start) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= fb_rd_en;
      for (int i = 1; i < RD_LATENCY; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; no reset needed since count gates visibility
  always_ff @(posedge VGA_CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Sticky underrun: request against an empty FIFO, cleared only by reset
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST)
      underrun <= 1'b0;
    else if (pix_req && !pix_valid && !frame_start)
      underrun <= 1'b1;
  end

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  localparam int BAR_W = H_VISIBLE / 8;
  localparam int CLW   = $clog2(H_VISIBLE);

  logic [CLW-1:0] col, bar_pos;
  logic [2:0]     bar;
  logic           unused_rd_data;

  assign unused_rd_data = ^fb_rd_data;

  // Column/bar tracking of the pixel being written; restarts every line
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST || frame_start) begin
      col     <= '0;
      bar_pos <= '0;
      bar     <= '0;
    end else if (push) begin
      if (col == CLW'(H_VISIBLE - 1)) begin
        col     <= '0;
        bar_pos <= '0;
        bar     <= '0;
      end else begin
        col <= col + 1'b1;
        if (bar_pos == CLW'(BAR_W - 1)) begin
          bar_pos <= '0;
          bar     <= bar + 1'b1;
        end else begin
          bar_pos <= bar_pos + 1'b1;
        end
      end
    end
  end

  // Bar palette, left to right
  always_comb begin
    case (bar)
      3'd0:    wr_data = 12'hFFF;
      3'd1:    wr_data = 12'hFF0;
      3'd2:    wr_data = 12'h0FF;
      3'd3:    wr_data = 12'h0F0;
      3'd4:    wr_data = 12'hF0F;
      3'd5:    wr_data = 12'hF00;
      3'd6:    wr_data = 12'h00F;
      default: wr_data = 12'h000;
    endcase
  end
`else
  assign wr_data = fb_rd_data;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a 2-cycle memory returning addr[11:0].
// Frame shrunk to 800x8 so a whole frame fits in a short run.
module tb_vga_pixel_fetch;

  localparam int H = 800;
  localparam int V = 8;
  localparam int NPIX = H * V;

  logic        VGA_CLK = 1'b0;
  logic        VGA_RST = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        underrun;
  logic        fb_rd_en;
  logic [18:0] fb_rd_addr;
  logic [11:0] fb_rd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_pixel_fetch #(
    .H_VISIBLE(H), .V_VISIBLE(V), .FIFO_DEPTH(16), .RD_LATENCY(2), .ADDR_W(19)
  ) dut (
    .VGA_CLK(VGA_CLK), .VGA_RST(VGA_RST), .frame_start(frame_start),
    .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data)
  );

  // memory model: data for the address strobed in cycle N is on the bus in cycle N+2
  logic [11:0] mem_d1 = '0, mem_d2 = '0;
  always @(posedge VGA_CLK) begin
    mem_d1 <= fb_rd_addr[11:0];
    mem_d2 <= mem_d1;
  end
  assign fb_rd_data = mem_d2;

  // read tracker: counts reads since last frame_start, checks linear addressing
  int          rd_cnt = 0;
  int          addr_err = 0;
  logic [18:0] last_addr = '0;
  always @(posedge VGA_CLK) begin
    if (VGA_RST || frame_start) begin
      rd_cnt <= 0;
    end else if (fb_rd_en) begin
      if (fb_rd_addr != 19'(rd_cnt)) addr_err <= addr_err + 1;
      rd_cnt    <= rd_cnt + 1;
      last_addr <= fb_rd_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge VGA_CLK);
  endtask

  initial begin
    int k, bad, first;
    logic seen_en, seen_vld, seen_un;

    // reset state
    repeat (3) step();
    VGA_RST = 1'b0;
    step();
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_rd_addr", fb_rd_addr, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_underrun", underrun, 0);

    // idle for 100 cycles with no frame_start
    seen_en = 0; seen_vld = 0; seen_un = 0;
    for (int c = 0; c < 100; c++) begin
      seen_en  |= fb_rd_en;
      seen_vld |= pix_valid;
      seen_un  |= underrun;
      step();
    end
    chk("idle_rd_en", seen_en, 0);
    chk("idle_valid", seen_vld, 0);
    chk("idle_underrun", seen_un, 0);

    // fill from frame_start with no consumer
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_no_rd_same_cycle", fb_rd_en, 0);
    chk("fs_empty", pix_valid, 0);
    step();
    chk("first_rd_en", fb_rd_en, 1);
    chk("first_rd_addr", fb_rd_addr, 0);
    step(); step();
    chk("valid_not_early", pix_valid, 0);
    step();
    chk("fill_latency", pix_valid, 1);
    chk("first_pix", pix_data, 0);
    repeat (30) step();
    chk("fill_reads", rd_cnt, 16);
    chk("fill_last_addr", last_addr, 15);
    chk("full_no_rd", fb_rd_en, 0);
    chk("full_valid", pix_valid, 1);

    // stream from full: in-order pixels, then run on until address 1234
    pix_req = 1'b1;
    k = 0; bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if (k >= 800 && fb_rd_addr == 19'd1234) break;
      if (!pix_valid || pix_data != k[11:0]) bad++;
      k++;
      step();
    end
    chk("stream_errs", bad, 0);
    chk("stream_min_800", k >= 800, 1);
    chk("stream_at_1234", fb_rd_addr, 1234);
    chk("stream_inflight", fb_rd_en, 1);
    chk("stream_underrun", underrun, 0);

    // mid-frame restart with reads in flight and a concurrent request
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_req = 1'b0;
    chk("restart_flush", pix_valid, 0);
    chk("restart_req_ignored", underrun, 0);
    for (int c = 0; c < 20 && !pix_valid; c++) step();
    chk("restart_fill", pix_valid, 1);
    first = int'(pix_data);
    chk("restart_first_addr0", first, 0);

    // full frame, consumed every cycle
    pix_req = 1'b1;
    k = 0; bad = 0;
    for (int c = 0; c < 10000 && k < NPIX; c++) begin
      if (pix_valid) begin
        if (pix_data != k[11:0]) bad++;
        k++;
      end else begin
        bad++;
      end
      step();
    end
    pix_req = 1'b0;
    chk("frame_pops", k, NPIX);
    chk("frame_errs", bad, 0);
    chk("frame_underrun", underrun, 0);
    chk("frame_reads", rd_cnt, NPIX);
    chk("frame_last_addr", last_addr, NPIX - 1);
    chk("frame_addr_seq", addr_err, 0);
    chk("frame_drained", pix_valid, 0);
    seen_en = 0;
    for (int c = 0; c < 50; c++) begin
      seen_en |= fb_rd_en;
      step();
    end
    chk("done_no_rd", seen_en, 0);

    // underrun on empty request, sticky across frame_start, cleared by reset
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    chk("underrun_set", underrun, 1);
    chk("empty_data", pix_data, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (10) step();
    chk("underrun_sticky", underrun, 1);
    VGA_RST = 1'b1;
    step(); step();
    VGA_RST = 1'b0;
    step();
    chk("underrun_cleared", underrun, 0);
    chk("rst2_valid", pix_valid, 0);
    chk("rst2_rd_en", fb_rd_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
